sub_serial: RTL



---
 rtl/sub_serial_pkg.sv | 14 +
 rtl/sub_full.sv | 27 ++
 rtl/sub_serial.sv | 108 ++++++++++
 3 files changed

// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   - state_e      : FSM state encoding (IDLE / RUN / DONE)
//   - DEFAULT_WIDTH: default operand/result width
package sub_serial_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_full.sv
// One-bit full subtractor built from two half subtractors and an OR of their borrows.
// Ports:
//   A, B : minuend / subtrahend bit
//   Bi   : borrow in
//   D    : difference bit  A ^ B ^ Bi
//   Bo   : borrow out      (~A & B) | (~(A ^ B) & Bi)
module sub_full (
  input  logic A,
  input  logic B,
  input  logic Bi,
  output logic D,
  output logic Bo
);

  logic hd1, hb1, hb2;

  // First half subtractor: A - B
  assign hd1 = A ^ B;
  assign hb1 = ~A & B;

  // Second half subtractor: (A - B) - Bi
  assign D   = hd1 ^ Bi;
  assign hb2 = ~hd1 & Bi;

  assign Bo  = hb1 | hb2;

endmodule

// File: rtl/sub_serial.sv
// Bit-serial subtractor: D = A - B - Bi, one bit per clock, LSB first, through a single
// full-subtractor cell. Operands enter on an in_valid/in_ready handshake; the registered
// result is held on an out_valid/out_ready handshake until accepted.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (in_ready high only when idle)
//   A, B, Bi            : minuend, subtrahend, borrow-in
//   out_valid, out_ready: result handshake (out_valid high only when done)
//   D, Bo, V            : difference, borrow-out, signed overflow
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             V
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, d_q;
  logic [CW-1:0]    cnt;
  logic             bw, v_q, a_msb, b_msb;
  logic             cell_d, cell_bo;
  logic             accept, last_bit;

  sub_full u_cell (
    .A  (a_sh[0]),
    .B  (b_sh[0]),
    .Bi (bw),
    .D  (cell_d),
    .Bo (cell_bo)
  );

  assign accept   = in_valid & in_ready;
  assign last_bit = (state_q == ST_RUN) && (cnt == LAST);

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cnt == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      d_q     <= '0;
      cnt     <= '0;
      bw      <= 1'b0;
      v_q     <= 1'b0;
      a_msb   <= 1'b0;
      b_msb   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_sh  <= A;
        b_sh  <= B;
        bw    <= Bi;
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
        cnt   <= '0;
        v_q   <= 1'b0;
      end else if (state_q == ST_RUN) begin
        // Result fills from the top so that after WIDTH shifts bit 0 sits at the LSB.
        d_q  <= {cell_d, d_q[WIDTH-1:1]};
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        bw   <= cell_bo;
        cnt  <= cnt + CW'(1);
        // The final cell output is the result MSB, so overflow is settled here.
        if (last_bit) v_q <= (a_msb ^ b_msb) & (a_msb ^ cell_d);
      end
    end
  end

  assign D  = d_q;
  assign Bo = bw;
  assign V  = v_q;

endmodule
